// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read bus between the fetch stage (master) and memory (slave).
//   mem_rd    master->slave  read request, held until mem_ready
//   mem_addr  master->slave  read address, stable while mem_rd=1
//   mem_rdata slave->master  read data, valid when mem_ready=1
//   mem_ready slave->master  data available for the current request
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    modport master(output mem_rd, mem_addr, input mem_rdata, mem_ready);
    modport slave(input mem_rd, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage holding PC and IR, reading words over a ready/valid memory bus.
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   run          leave IDLE and start fetching from PC
//   mem          memory read bus (master side)
//   instr_out    IR contents; instr_valid marks it unconsumed
//   instr_taken  controller consumes instr_out; pc_load/pc_target redirect PC on take
//   pc_out       address of the word in instr_out
//   halted       a HALT opcode was consumed; only reset leaves this state
module instr_fetch #(
    parameter int         ADDR_W  = 8,
    parameter int         DATA_W  = 16,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    instr_fetch_if.master      mem,
    output logic [DATA_W-1:0]  instr_out,
    output logic               instr_valid,
    input  logic               instr_taken,
    input  logic               pc_load,
    input  logic [ADDR_W-1:0]  pc_target,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);
    typedef enum logic [1:0] {IDLE, REQ, VALID, HALT} state_t;
    state_t            state, state_d;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              is_halt;
    logic              take;
    assign is_halt     = ir[DATA_W-1 -: 3] == HALT_OP;
    assign take        = state == VALID && instr_taken;
    assign mem.mem_rd   = state == REQ;
    assign mem.mem_addr = state == REQ ? pc : '0;
    assign instr_valid = state == VALID;
    assign halted      = state == HALT;
    assign instr_out   = ir;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:  state_d = run ? REQ : IDLE;
            REQ:   state_d = mem.mem_ready ? VALID : REQ;
            VALID: state_d = !instr_taken ? VALID : is_halt ? HALT : REQ;
            HALT:  state_d = HALT;
        endcase
    end
    // PC is advanced at capture time, so a plain take needs no PC update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= '0;
            ir     <= '0;
            pc_out <= '0;
        end else if (state == REQ && mem.mem_ready) begin
            ir     <= mem.mem_rdata;
            pc_out <= pc;
            pc     <= pc + 1'b1;
        end else if (take && !is_halt && pc_load) begin
            pc     <= pc_target;
        end
    end
endmodule
